decode_stage: RTL

Registered, parametrised RV32I decode stage with a valid/ready handshake on both sides. It sits between fetch and execute. Each accepted instruction is decoded into the standard rv32i control bundle and written into a DEPTH-entry FIFO, which absorbs execute-side stalls. Beyond the base decoder, it adds optional RV32M decode, explicit illegal-instruction detection, ECALL/EBREAK flags and a pipeline flush.

---
 rtl/decode_stage.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetch-side word into a control
// bundle, buffered in a DEPTH-entry FIFO that absorbs execute-side stalls.

package rv32i;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } inst_fields_s;

    typedef union packed {
        logic [31:0]  raw;
        inst_fields_s f;
    } rv32i_inst_u;

    // The eight RV32M operations must stay consecutive, in funct3 order.
    typedef enum logic [4:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
        ALU_BGEU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU,
        ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {ALU_INPUT_NONE, ALU_INPUT_REG, ALU_INPUT_IMM, ALU_INPUT_PC} alu_input_type_e;
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC} wb_from_e;
    typedef enum logic {REG_WD, REG_WE} reg_we_e;
    typedef enum logic {MEM_LOAD, MEM_STORE} mem_op_e;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        alu_op_e         alu_op;
        alu_input_type_e alu_input1_type;
        alu_input_type_e alu_input2_type;
        wb_from_e        wb_from;
        reg_we_e         r_we;
        mem_op_e         mem_op;
        logic [2:0]      funct3;
        logic            illegal;
        logic            ecall;
        logic            ebreak;
    } decoded_s;

    function automatic decoded_s nop_bundle();
        decoded_s d;
        d.rs1             = '0;
        d.rs2             = '0;
        d.rd              = '0;
        d.imm             = '0;
        d.alu_op          = ALU_NOP;
        d.alu_input1_type = ALU_INPUT_NONE;
        d.alu_input2_type = ALU_INPUT_NONE;
        d.wb_from         = WB_NONE;
        d.r_we            = REG_WD;
        d.mem_op          = MEM_LOAD;
        d.funct3          = '0;
        d.illegal         = 1'b0;
        d.ecall           = 1'b0;
        d.ebreak          = 1'b0;
        return d;
    endfunction

endpackage

module decode_stage
    import rv32i::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter bit          ENABLE_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_pc,
    input  rv32i_inst_u     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [31:0]     out_imm,
    output alu_op_e         out_alu_op,
    output alu_input_type_e out_alu_input1_type,
    output alu_input_type_e out_alu_input2_type,
    output wb_from_e        out_wb_from,
    output reg_we_e         out_r_we,
    output mem_op_e         out_mem_op,
    output logic [2:0]      out_funct3,
    output logic            out_illegal,
    output logic            out_ecall,
    output logic            out_ebreak
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        decoded_s    dec;
    } entry_s;

    logic [31:0]   w;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
    logic          illegal;
    decoded_s      dec;
    entry_s        fifo_mem [DEPTH];
    entry_s        head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          push, pop;

    assign w     = in_instr.raw;
    assign f3    = w[14:12];
    assign f7    = w[31:25];
    assign imm_i = {{20{w[31]}}, w[31:20]};
    assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
    assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    assign imm_u = {w[31:12], 12'h000};
    assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

    function automatic alu_op_e base_alu_op(logic [2:0] funct3, logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e branch_alu_op(logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_BEQ;
            3'b001:  return ALU_BNE;
            3'b100:  return ALU_BLT;
            3'b101:  return ALU_BGE;
            3'b110:  return ALU_BLTU;
            default: return ALU_BGEU;
        endcase
    endfunction

    always_comb begin
        dec     = nop_bundle();
        illegal = 1'b0;
        case (opcode_e'(w[6:0]))
            OPC_LUI, OPC_AUIPC: begin
                dec.rd              = w[11:7];
                dec.imm             = imm_u;
                dec.alu_op          = ALU_ADD;
                dec.alu_input1_type = (w[5]) ? ALU_INPUT_NONE : ALU_INPUT_PC;
                dec.alu_input2_type = ALU_INPUT_IMM;
                dec.wb_from         = WB_ALU;
                dec.r_we            = REG_WE;
            end
            OPC_JAL: begin
                dec.rd              = w[11:7];
                dec.imm             = imm_j;
                dec.alu_op          = ALU_ADD;
                dec.alu_input1_type = ALU_INPUT_PC;
                dec.alu_input2_type = ALU_INPUT_IMM;
                dec.wb_from         = WB_PC;
                dec.r_we            = REG_WE;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                dec.rd              = w[11:7];
                dec.rs1             = w[19:15];
                dec.imm             = imm_i;
                dec.funct3          = f3;
                dec.alu_op          = ALU_ADD;
                dec.alu_input1_type = ALU_INPUT_REG;
                dec.alu_input2_type = ALU_INPUT_IMM;
                dec.r_we            = REG_WE;
                dec.wb_from         = WB_ALU;
                if (w[6:0] == OPC_JALR) begin
                    dec.wb_from = WB_PC;
                    illegal     = (f3 != 3'b000);
                end else if (w[6:0] == OPC_LOAD) begin
                    dec.wb_from = WB_MEM;
                    illegal     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
                end else begin
                    dec.alu_op = base_alu_op(f3, (f3 == 3'b101) && f7[5]);
                    illegal    = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                                 ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
                end
            end
            OPC_BRANCH: begin
                dec.rs1             = w[19:15];
                dec.rs2             = w[24:20];
                dec.imm             = imm_b;
                dec.funct3          = f3;
                dec.alu_op          = branch_alu_op(f3);
                dec.alu_input1_type = ALU_INPUT_REG;
                dec.alu_input2_type = ALU_INPUT_REG;
                illegal             = (f3[2:1] == 2'b01);
            end
            OPC_STORE: begin
                dec.rs1             = w[19:15];
                dec.rs2             = w[24:20];
                dec.imm             = imm_s;
                dec.funct3          = f3;
                dec.alu_op          = ALU_ADD;
                dec.alu_input1_type = ALU_INPUT_REG;
                dec.alu_input2_type = ALU_INPUT_IMM;
                dec.mem_op          = MEM_STORE;
                illegal             = (f3 >= 3'b011);
            end
            OPC_OP: begin
                dec.rd              = w[11:7];
                dec.rs1             = w[19:15];
                dec.rs2             = w[24:20];
                dec.funct3          = f3;
                dec.alu_input1_type = ALU_INPUT_REG;
                dec.alu_input2_type = ALU_INPUT_REG;
                dec.wb_from         = WB_ALU;
                dec.r_we            = REG_WE;
                if (ENABLE_M && (f7 == 7'b0000001))
                    dec.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(f3));
                else if ((f7 == 7'b0000000) ||
                         ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))))
                    dec.alu_op = base_alu_op(f3, f7[5]);
                else
                    illegal = 1'b1;
            end
            OPC_MISC_MEM: ;
            OPC_SYSTEM: begin
                dec.ecall  = (w == 32'h0000_0073);
                dec.ebreak = (w == 32'h0010_0073);
                illegal    = !(dec.ecall || dec.ebreak);
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec         = nop_bundle();
            dec.illegal = 1'b1;
        end
    end

    assign in_ready  = !rst && (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW + 1)'(1);
            else if (pop && !push) count <= count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{pc: in_pc, dec: dec};
    end

    always_comb begin
        head.pc  = '0;
        head.dec = nop_bundle();
        if (out_valid) head = fifo_mem[rd_ptr];
    end

    assign out_pc              = head.pc;
    assign out_rs1             = head.dec.rs1;
    assign out_rs2             = head.dec.rs2;
    assign out_rd              = head.dec.rd;
    assign out_imm             = head.dec.imm;
    assign out_alu_op          = head.dec.alu_op;
    assign out_alu_input1_type = head.dec.alu_input1_type;
    assign out_alu_input2_type = head.dec.alu_input2_type;
    assign out_wb_from         = head.dec.wb_from;
    assign out_r_we            = head.dec.r_we;
    assign out_mem_op          = head.dec.mem_op;
    assign out_funct3          = head.dec.funct3;
    assign out_illegal         = head.dec.illegal;
    assign out_ecall           = head.dec.ecall;
    assign out_ebreak          = head.dec.ebreak;

endmodule
